// File: rtl/game_state_ctrl_pkg.sv
// ============================================================================
// game_state_ctrl_pkg : shared state codes, frame limits and winner codes
// Rev 1.0
// ============================================================================
`default_nettype none

package game_state_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_MENU  = 3'b000,
      ST_READY = 3'b001,
      ST_PLAY  = 3'b010,
      ST_DYING = 3'b011,
      ST_OVER  = 3'b100
   } game_state_t;

   localparam logic [7:0] DYING_FRAMES     = 8'd60;
   localparam logic [7:0] OVER_LOCK_FRAMES = 8'd30;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_RED  = 2'b01;
   localparam logic [1:0] WIN_BLUE = 2'b10;
   localparam logic [1:0] WIN_TIE  = 2'b11;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/game_state_ctrl_btn_edge.sv
// ============================================================================
// btn_edge : rising-edge detector for one debounced button level
// Rev 1.0
// ============================================================================
`default_nettype none

module btn_edge (
   input  logic clk,
   input  logic rst,
   input  logic i_btn,
   output logic o_rise
);

   logic r_prev;
   logic r_armed;

   // r_armed masks the first clk after reset so a button held through reset is not seen as a press
   always_ff @(posedge clk) begin
      if (rst) begin
         r_prev  <= 1'b0;
         r_armed <= 1'b0;
      end else begin
         r_prev  <= i_btn;
         r_armed <= 1'b1;
      end
   end

   assign o_rise = r_armed & i_btn & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/game_state_ctrl.sv
// ============================================================================
// game_state_ctrl : menu/ready/play/dying/over sequencer with score and winner
// Rev 1.0
// ============================================================================
`default_nettype none

module game_state_ctrl
   import game_state_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_tick,
   input  logic       btn_flap,
   input  logic       btn_flap_blue,
   input  logic       btn_mode,
   input  logic       hit_red,
   input  logic       hit_blue,
   input  logic       pass_pulse,
   output logic [2:0] state,
   output logic       mode,
   output logic [7:0] score,
   output logic [1:0] winner,
   output logic       start_pulse
);

   logic        w_flap_rise;
   logic        w_blue_rise;
   logic        w_mode_rise;

   game_state_t r_state,  w_state_nxt;
   logic        r_mode,   w_mode_nxt;
   logic [7:0]  r_score,  w_score_nxt;
   logic [1:0]  r_winner, w_winner_nxt;
   logic        r_start,  w_start_nxt;
   logic [7:0]  r_frames, w_frames_nxt;

   btn_edge u_edge_flap (.clk(clk), .rst(rst), .i_btn(btn_flap),      .o_rise(w_flap_rise));
   btn_edge u_edge_blue (.clk(clk), .rst(rst), .i_btn(btn_flap_blue), .o_rise(w_blue_rise));
   btn_edge u_edge_mode (.clk(clk), .rst(rst), .i_btn(btn_mode),      .o_rise(w_mode_rise));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_MENU;
         r_mode   <= 1'b0;
         r_score  <= 8'd0;
         r_winner <= WIN_NONE;
         r_start  <= 1'b0;
         r_frames <= 8'd0;
      end else begin
         r_state  <= w_state_nxt;
         r_mode   <= w_mode_nxt;
         r_score  <= w_score_nxt;
         r_winner <= w_winner_nxt;
         r_start  <= w_start_nxt;
         r_frames <= w_frames_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_mode_nxt   = r_mode;
      w_score_nxt  = r_score;
      w_winner_nxt = r_winner;
      w_start_nxt  = 1'b0;
      w_frames_nxt = frame_tick ? sat_inc8(r_frames) : r_frames;

      case (r_state)
         ST_MENU: begin
            if (w_mode_rise)
               w_mode_nxt = ~r_mode;
            if (w_flap_rise) begin
               w_state_nxt  = ST_READY;
               w_score_nxt  = 8'd0;
               w_winner_nxt = WIN_NONE;
            end
         end
         ST_READY: begin
            if (w_flap_rise || (r_mode && w_blue_rise)) begin
               w_state_nxt = ST_PLAY;
               w_start_nxt = 1'b1;
            end
         end
         ST_PLAY: begin
            // Score is updated even on the clk that ends the game
            if (pass_pulse)
               w_score_nxt = sat_inc8(r_score);
            if (r_mode) begin
               if (hit_red || hit_blue) begin
                  w_state_nxt  = ST_DYING;
                  w_frames_nxt = 8'd0;
                  if (hit_red && hit_blue) w_winner_nxt = WIN_TIE;
                  else if (hit_red)        w_winner_nxt = WIN_BLUE;
                  else                     w_winner_nxt = WIN_RED;
               end
            end else if (hit_red) begin
               w_state_nxt  = ST_DYING;
               w_frames_nxt = 8'd0;
               w_winner_nxt = WIN_NONE;
            end
         end
         ST_DYING: begin
            if (frame_tick && (sat_inc8(r_frames) == DYING_FRAMES)) begin
               w_state_nxt  = ST_OVER;
               w_frames_nxt = 8'd0;
            end
         end
         ST_OVER: begin
            if ((r_frames >= OVER_LOCK_FRAMES) && w_flap_rise)
               w_state_nxt = ST_MENU;
         end
         default: w_state_nxt = ST_MENU;
      endcase
   end

   assign state       = r_state;
   assign mode        = r_mode;
   assign score       = r_score;
   assign winner      = r_winner;
   assign start_pulse = r_start;

endmodule

`default_nettype wire

// File: tb/tb_game_state_ctrl.sv
// ============================================================================
// tb_game_state_ctrl : directed self-checking bench for game_state_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_game_state_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       frame_tick = 1'b0;
   logic       btn_flap = 1'b0;
   logic       btn_flap_blue = 1'b0;
   logic       btn_mode = 1'b0;
   logic       hit_red = 1'b0;
   logic       hit_blue = 1'b0;
   logic       pass_pulse = 1'b0;
   logic [2:0] state;
   logic       mode;
   logic [7:0] score;
   logic [1:0] winner;
   logic       start_pulse;

   int n_assert = 0;
   int n_fail   = 0;

   game_state_ctrl dut (
      .clk(clk), .rst(rst), .frame_tick(frame_tick),
      .btn_flap(btn_flap), .btn_flap_blue(btn_flap_blue), .btn_mode(btn_mode),
      .hit_red(hit_red), .hit_blue(hit_blue), .pass_pulse(pass_pulse),
      .state(state), .mode(mode), .score(score), .winner(winner),
      .start_pulse(start_pulse)
   );

   always #5 clk = ~clk;

   // inputs change and outputs are sampled on the falling edge
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic press(input int which);
      case (which)
         0: btn_flap      = 1'b1;
         1: btn_flap_blue = 1'b1;
         default: btn_mode = 1'b1;
      endcase
      step();
      btn_flap = 1'b0; btn_flap_blue = 1'b0; btn_mode = 1'b0;
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) begin
         frame_tick = 1'b1; step();
         frame_tick = 1'b0; step();
      end
   endtask

   initial begin
      @(negedge clk);
      step(); step();
      rst = 1'b0;
      chk("rst_state", {5'd0, state}, 8'd0);
      chk("rst_mode", {7'd0, mode}, 8'd0);
      chk("rst_score", score, 8'd0);
      chk("rst_winner", {6'd0, winner}, 8'd0);
      chk("rst_start", {7'd0, start_pulse}, 8'd0);

      // flap held through reset must not register as a press
      rst = 1'b1; btn_flap = 1'b1; step();
      rst = 1'b0; step(); step();
      chk("held_thru_rst", {5'd0, state}, 8'd0);
      btn_flap = 1'b0; step();

      // mode toggles once per press, however long held
      btn_mode = 1'b1; step();
      chk("mode_tog1", {7'd0, mode}, 8'd1);
      step(); step();
      chk("mode_held", {7'd0, mode}, 8'd1);
      btn_mode = 1'b0; step();
      press(2);
      chk("mode_tog2", {7'd0, mode}, 8'd0);
      step();
      chk("menu_before_flap", {5'd0, state}, 8'd0);
      press(0);
      chk("ready", {5'd0, state}, 8'd1);
      chk("ready_score", score, 8'd0);
      chk("ready_mode", {7'd0, mode}, 8'd0);

      // blue is ignored in single player
      press(1);
      chk("blue_ignored_m0", {5'd0, state}, 8'd1);
      step();
      press(0);
      chk("play_m0", {5'd0, state}, 8'd2);
      chk("start_hi_m0", {7'd0, start_pulse}, 8'd1);
      step();
      chk("start_lo_m0", {7'd0, start_pulse}, 8'd0);

      pass_pulse = 1'b1;
      step(); step(); step();
      chk("score3", score, 8'd3);
      for (int i = 0; i < 297; i++) step();
      pass_pulse = 1'b0;
      chk("score_sat", score, 8'd255);
      hit_blue = 1'b1; step(); hit_blue = 1'b0;
      chk("hit_blue_ign_m0", {5'd0, state}, 8'd2);
      hit_red = 1'b1; pass_pulse = 1'b1; step();
      hit_red = 1'b0; pass_pulse = 1'b0;
      chk("dying_m0", {5'd0, state}, 8'd3);
      chk("score_sat_hit", score, 8'd255);
      chk("winner_m0", {6'd0, winner}, 8'd0);

      frames(59);
      chk("dying_59", {5'd0, state}, 8'd3);
      frames(1);
      chk("over_60", {5'd0, state}, 8'd4);

      frames(10);
      press(0);
      chk("over_lock10", {5'd0, state}, 8'd4);
      step();
      press(2);
      chk("over_mode_ign", {7'd0, mode}, 8'd0);
      step();
      frames(21);
      press(0);
      chk("over_to_menu", {5'd0, state}, 8'd0);
      chk("menu_score_held", score, 8'd255);
      step();

      // simultaneous mode+flap in MENU
      btn_mode = 1'b1; btn_flap = 1'b1; step();
      btn_mode = 1'b0; btn_flap = 1'b0;
      chk("simul_mode", {7'd0, mode}, 8'd1);
      chk("simul_state", {5'd0, state}, 8'd1);
      chk("simul_score", score, 8'd0);
      step();
      press(1);
      chk("play_blue", {5'd0, state}, 8'd2);
      chk("start_hi_m1", {7'd0, start_pulse}, 8'd1);
      step();
      chk("start_lo_m1", {7'd0, start_pulse}, 8'd0);
      pass_pulse = 1'b1; step(); step(); pass_pulse = 1'b0;
      hit_red = 1'b1; hit_blue = 1'b1; step();
      hit_red = 1'b0; hit_blue = 1'b0;
      chk("tie_winner", {6'd0, winner}, 8'd3);
      chk("tie_state", {5'd0, state}, 8'd3);
      chk("tie_score", score, 8'd2);
      frames(60);
      chk("tie_over", {5'd0, state}, 8'd4);

      // second two-player game: red hit only, then reset mid-DYING
      frames(30);
      press(0);
      chk("menu2", {5'd0, state}, 8'd0);
      chk("menu2_winner_held", {6'd0, winner}, 8'd3);
      step();
      press(0);
      chk("ready2_winner", {6'd0, winner}, 8'd0);
      step();
      press(0);
      chk("play2", {5'd0, state}, 8'd2);
      hit_red = 1'b1; step(); hit_red = 1'b0;
      chk("red_hit_winner", {6'd0, winner}, 8'd2);
      frames(20);
      chk("dying_20", {5'd0, state}, 8'd3);
      rst = 1'b1; step(); rst = 1'b0;
      chk("rst_dying_state", {5'd0, state}, 8'd0);
      chk("rst_dying_mode", {7'd0, mode}, 8'd0);
      chk("rst_dying_score", score, 8'd0);
      chk("rst_dying_winner", {6'd0, winner}, 8'd0);
      chk("rst_dying_start", {7'd0, start_pulse}, 8'd0);

      // third game: blue hit only
      step();
      press(2);
      step();
      press(0);
      step();
      press(0);
      chk("play3", {5'd0, state}, 8'd2);
      hit_blue = 1'b1; step(); hit_blue = 1'b0;
      chk("blue_hit_winner", {6'd0, winner}, 8'd1);
      chk("blue_hit_state", {5'd0, state}, 8'd3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/game_state_ctrl.md
GAME_STATE_CTRL -- requirements
Module: game_state_ctrl

Interface
REQ-001 clk  in  1  system clock; every flop is on its rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 frame_tick  in  1  one-clk pulse per VGA frame, 60 Hz.
REQ-004 btn_flap  in  1  debounced level, red-bird button.
REQ-005 btn_flap_blue  in  1  debounced level, blue-bird button.
REQ-006 btn_mode  in  1  debounced level, single/two-player toggle.
REQ-007 hit_red  in  1  level; red bird touches a pipe or the ground.
REQ-008 hit_blue  in  1  level; blue bird touches a pipe or the ground.
REQ-009 pass_pulse  in  1  one-clk pulse when the birds clear a pipe pair.
REQ-010 state  out  3  game state; feeds the bird position/state selector.
REQ-011 mode  out  1  0 = single player, 1 = two player.
REQ-012 score  out  8  pipes passed in the current game.
REQ-013 winner  out  2  00 none, 01 red wins, 10 blue wins, 11 tie.
REQ-014 start_pulse  out  1  one-clk pulse on READY->PLAY; restarts the pipe/physics engines.

Function
REQ-015 The state encoding SHALL be: MENU=000, READY=001, PLAY=010, DYING=011, OVER=100; 101-111 SHALL go to MENU on the next clk.
REQ-016 Each button SHALL be rising-edge detected with one registered sample; a press SHALL act on the clk after its edge and SHALL count once however long it is held.
REQ-017 In MENU, a btn_mode press SHALL toggle mode; in all other states btn_mode SHALL be ignored and mode SHALL hold.
REQ-018 In MENU, a btn_flap press SHALL go to READY, clear score and set winner=00.
REQ-019 If btn_mode and btn_flap edges arrive in the same clk in MENU, mode SHALL toggle and the state SHALL go to READY together.
REQ-020 In READY, a btn_flap press (or a btn_flap_blue press when mode=1) SHALL go to PLAY and assert start_pulse for exactly one clk.
REQ-021 In PLAY, pass_pulse SHALL increment score and saturate at 255.
REQ-022 In PLAY with mode=0, hit_red SHALL go to DYING with winner=00; hit_blue SHALL be ignored.
REQ-023 In PLAY with mode=1: hit_red only -> winner=10; hit_blue only -> winner=01; both in the same clk -> winner=11; each case -> DYING.
REQ-024 A pass_pulse in the same clk as a terminating hit SHALL still be counted.
REQ-025 An 8-bit frame counter SHALL clear on entry to DYING and to OVER, and SHALL increment only on frame_tick.
REQ-026 DYING SHALL go to OVER on the frame_tick that brings the counter to 60 (DYING_FRAMES).
REQ-027 In OVER, button presses SHALL be ignored until the counter reaches 30 (OVER_LOCK_FRAMES).
REQ-028 After the OVER lockout, a btn_flap press SHALL go to MENU; score, winner and mode SHALL hold until the next MENU->READY.
REQ-029 Outputs SHALL be registered; state SHALL change one clk after the qualifying input.

Reset
REQ-030 On rst high at a clk edge: state=MENU, mode=0, score=0, winner=00, start_pulse=0, frame counter=0, edge-detect registers=0.
REQ-031 rst SHALL abort any state immediately, including mid-DYING.
REQ-032 Buttons held through reset SHALL NOT produce an edge on the first clk after release.

Structure
REQ-033 The state codes, DYING_FRAMES, OVER_LOCK_FRAMES and the winner codes SHALL be defined in the shared game package.
REQ-034 The three-button edge detector SHALL be one sub-module, btn_edge, instantiated per button.

Verification
REQ-035 Reset, toggle btn_mode twice, press btn_flap -> mode=0, state 000->001 one clk after the flap edge, score=0.
REQ-036 mode=1, READY, press btn_flap_blue -> state=010, start_pulse high for exactly 1 clk.
REQ-037 PLAY, 300 pass_pulses -> score=255 (saturated); a hit_red with a pass_pulse in the same clk -> score still 255, state=011.
REQ-038 mode=1, PLAY, hit_red and hit_blue in the same clk -> winner=11, state=011; after 60 frame_ticks -> state=100.
REQ-039 OVER, btn_flap at 10 frames -> no change; btn_flap at 31 frames -> state=000, score held.
REQ-040 rst pulse in DYING at frame 20 -> every output at its reset value on the next clk.
